picoview_regfile: RTL and testbench
===================================

# picoview_regfile

Parametrised SPI-facing register bank for picoview designs, sitting between `simple_spi` and the sampling cores. It decodes the 8-bit command byte, serves reads from read-only status inputs, read/write configuration registers and a fixed device-ID address, and emits per-register write strobes and one-cycle control pulses. It also supports burst transfers that auto-increment the register pointer.

## Interface
- `DATA_WIDTH`, 32, width of every register and SPI data word
- `NUM_RO`, 2, read-only registers at addresses 0..NUM_RO-1 (min 1); address 0 is control/status
- `NUM_REGS`, 7, total registers; RW registers occupy NUM_RO..NUM_REGS-1; NUM_REGS ≤ 127
- `DEVICE_ID`, 32'hC001CAFE, value returned at address 7'h7F
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd`  in  8  command byte; bit 7 = write, bits 6:0 = start address
- `cmd_valid`  in  1  one-cycle pulse; `cmd` valid
- `rx_data`  in  DATA_WIDTH  received data word
- `rx_valid`  in  1  one-cycle pulse; `rx_data` complete
- `tx_data`  out  DATA_WIDTH  word shifted out for the next transfer
- `ro_data`  in  NUM_RO*DATA_WIDTH  status inputs; slice k is read at address k
- `rw_data`  out  (NUM_REGS-NUM_RO)*DATA_WIDTH  RW register contents; slice j is address NUM_RO+j
- `wr_strobe`  out  NUM_REGS  one-cycle pulse on the written address
- `ctrl_pulse`  out  DATA_WIDTH  one-cycle copy of data written to address 0

## Operation
- FSM `IDLE` → `ACTIVE` on `cmd_valid`. `ACTIVE` → `ACTIVE` on each later `cmd_valid`, which re-latches the command. There is no return to `IDLE` except through reset.
- On `cmd_valid`: latch `is_write` and `ptr <= cmd[6:0]`; load `tx_data` with read(ptr).
- read(a): `ro_data` slice if a < NUM_RO; RW register if a < NUM_REGS; DEVICE_ID if a == 7'h7F; otherwise 0.
- On `rx_valid` in `ACTIVE` with `is_write`:
  - a == 0: `ctrl_pulse <= rx_data`.
  - 0 < a < NUM_RO: ignored.
  - RW address: store `rx_data`.
  - 7'h7F or unmapped: ignored.
  - `wr_strobe[a]` pulses for every mapped address, including read-only ones.
- `rx_valid` in `IDLE` is ignored.
- Simultaneous `cmd_valid` and `rx_valid`: the data goes to the old `ptr` under the old `is_write`; the new command then sets `ptr`, and `tx_data` reflects the new `ptr`.

## Timing
- Reset values: `tx_data`, `rw_data`, `wr_strobe` and `ctrl_pulse` are 0; FSM is `IDLE`; `ptr` is 0.
- `tx_data` is updated 1 cycle after `cmd_valid`.
- A write is visible on `rw_data` 1 cycle after `rx_valid`. `wr_strobe` and `ctrl_pulse` are registered, high exactly that one cycle, then 0.
- Burst enabled: `ptr` advances 1 cycle after `rx_valid` (reads and writes), and `tx_data` reloads from the new `ptr` in that same cycle.
  - NUM_REGS-1 wraps to 0.
  - 7'h7F and unmapped addresses do not advance.
- Reset asserted mid-burst returns to `IDLE` immediately; partial writes already committed are cleared.

## Configuration
- `PICOVIEW_REGFILE_BURST_EN` defined: auto-increment as described in Timing.
- `PICOVIEW_REGFILE_BURST_EN` undefined: `ptr` is fixed per command. Repeated words hit the same address, and `tx_data` is refreshed from the same address after each `rx_valid`.

## Structure
- Package `picoview_pkg` holds:
  - `REG_CONTROL`, `REG_ID` (7'h7F)
  - `CMD_WRITE_BIT` (7), `CMD_ADDR_MSB` (6)
  - `CONTROL_BIT_RUN` (0), `CONTROL_BIT_STATUS` (1)
  - FSM state typedef
- Sub-module `picoview_read_mux`: combinational read(a) over `ro_data`, RW array and DEVICE_ID, used for both load points of `tx_data`.

## Test plan
- Reset, then `cmd`=8'h7F → `tx_data`=32'hC001CAFE one cycle later; all strobes 0.
- `cmd`=8'h83, `rx_data`=32'h12345678 → `wr_strobe[3]` one cycle; `rw_data` slice 1 = 32'h12345678; readback with `cmd`=8'h03 returns it.
- `cmd`=8'h80, `rx_data`=32'h1 → `ctrl_pulse`=1 for exactly one cycle; `ro_data` slice 0 unaffected; RW registers unchanged.
- BURST_EN: `cmd`=8'h85 with words A, B, C → addr5=A, addr6=B, addr0 gets `ctrl_pulse`=C (wrap).
- No BURST_EN: same stimulus → addr5=C, addr6 unchanged.
- `cmd`=8'h90 write, then `rst_n` low mid-transfer → outputs 0, FSM `IDLE`; subsequent `rx_valid` without `cmd_valid` → no strobe.

Source files
------------

// File: rtl/picoview_pkg.sv
// Shared constants and FSM state type for the picoview SPI register bank.
package picoview_pkg;

    localparam logic [6:0] REG_CONTROL = 7'h00;
    localparam logic [6:0] REG_ID      = 7'h7F;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_MSB  = 6;

    localparam int CONTROL_BIT_RUN    = 0;
    localparam int CONTROL_BIT_STATUS = 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

endpackage

// File: rtl/picoview_read_mux.sv
// Combinational register read: status inputs, RW bank, device ID, else zero.
module picoview_read_mux
    import picoview_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RO     = 2,
    parameter int                    NUM_REGS   = 7,
    parameter logic [DATA_WIDTH-1:0] DEVICE_ID  = 32'hC001CAFE
) (
    input  logic [6:0]                             addr,
    input  logic [NUM_RO*DATA_WIDTH-1:0]           ro_data,
    input  logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0] rw_data,
    output logic [DATA_WIDTH-1:0]                  data
);

    localparam int NUM_RW = NUM_REGS - NUM_RO;

    always_comb begin
        data = '0;
        if (addr == REG_ID) begin
            data = DEVICE_ID;
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (addr == 7'(k)) begin
                data = ro_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int j = 0; j < NUM_RW; j++) begin
            if (addr == 7'(NUM_RO + j)) begin
                data = rw_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/picoview_regfile.sv
// SPI-facing register bank with write strobes and control pulses.
// Define PICOVIEW_REGFILE_BURST_EN to auto-increment the pointer per word.
module picoview_regfile
    import picoview_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RO     = 2,
    parameter int                    NUM_REGS   = 7,
    parameter logic [DATA_WIDTH-1:0] DEVICE_ID  = 32'hC001CAFE
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [7:0]                              cmd,
    input  logic                                    cmd_valid,
    input  logic [DATA_WIDTH-1:0]                   rx_data,
    input  logic                                    rx_valid,
    output logic [DATA_WIDTH-1:0]                   tx_data,
    input  logic [NUM_RO*DATA_WIDTH-1:0]            ro_data,
    output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0] rw_data,
    output logic [NUM_REGS-1:0]                     wr_strobe,
    output logic [DATA_WIDTH-1:0]                   ctrl_pulse
);

    localparam int         NUM_RW   = NUM_REGS - NUM_RO;
    localparam logic [6:0] LAST_REG = 7'(NUM_REGS - 1);

    state_e state_q, state_d;

    logic                                 is_write_q;
    logic [6:0]                           ptr_q;
    logic [6:0]                           ptr_adv;
    logic [6:0]                           cmd_addr;
    logic [6:0]                           rd_addr;
    logic                                 rx_act;
    logic                                 do_wr;
    logic                                 mapped;
    logic                                 store;
    logic [DATA_WIDTH-1:0]                rd_data;
    logic [DATA_WIDTH-1:0]                tx_next;
    logic [NUM_RW-1:0][DATA_WIDTH-1:0]    rw_q;

    assign cmd_addr = cmd[CMD_ADDR_MSB:0];
    assign rx_act   = rx_valid && (state_q == ST_ACTIVE);
    assign do_wr    = rx_act && is_write_q;
    assign mapped   = ptr_q < 7'(NUM_REGS);
    assign store    = do_wr && mapped && (ptr_q >= 7'(NUM_RO));

`ifdef PICOVIEW_REGFILE_BURST_EN
    assign ptr_adv = !mapped ? ptr_q :
                     (ptr_q == LAST_REG) ? 7'd0 : ptr_q + 7'd1;
`else
    assign ptr_adv = ptr_q;
`endif

    // A word stored this cycle must be seen by the reload, not the stale copy.
    assign rd_addr = cmd_valid ? cmd_addr : ptr_adv;
    assign tx_next = (store && rd_addr == ptr_q) ? rx_data : rd_data;
    assign rw_data = rw_q;

    picoview_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RO     (NUM_RO),
        .NUM_REGS   (NUM_REGS),
        .DEVICE_ID  (DEVICE_ID)
    ) u_read_mux (
        .addr    (rd_addr),
        .ro_data (ro_data),
        .rw_data (rw_q),
        .data    (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cmd_valid) begin
            state_d = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_q <= 1'b0;
            ptr_q      <= '0;
            tx_data    <= '0;
            rw_q       <= '0;
            wr_strobe  <= '0;
            ctrl_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_strobe[i] <= do_wr && (ptr_q == 7'(i));
            end
            ctrl_pulse <= (do_wr && ptr_q == REG_CONTROL) ? rx_data : '0;
            for (int j = 0; j < NUM_RW; j++) begin
                if (store && ptr_q == 7'(NUM_RO + j)) begin
                    rw_q[j] <= rx_data;
                end
            end
            if (cmd_valid) begin
                is_write_q <= cmd[CMD_WRITE_BIT];
                ptr_q      <= cmd_addr;
                tx_data    <= tx_next;
            end else if (rx_act) begin
                ptr_q      <= ptr_adv;
                tx_data    <= tx_next;
            end
        end
    end

endmodule

// File: tb/tb_picoview_regfile.sv
// Directed self-checking bench for picoview_regfile (default parameters).
module tb_picoview_regfile;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   cmd = '0;
    logic         cmd_valid = 1'b0;
    logic [31:0]  rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [31:0]  tx_data;
    logic [63:0]  ro_data = {32'hBBBB0001, 32'hAAAA0000};
    logic [159:0] rw_data;
    logic [6:0]   wr_strobe;
    logic [31:0]  ctrl_pulse;

    int tests = 0;
    int fails = 0;

    picoview_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .ro_data    (ro_data),
        .rw_data    (rw_data),
        .wr_strobe  (wr_strobe),
        .ctrl_pulse (ctrl_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] d);
        rx_data = d;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_tx", tx_data, 0);
        chk("rst_rw", rw_data, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_ctrl", ctrl_pulse, 0);
        rst_n = 1'b1;
        step();

        send_rx(32'hDEAD);
        chk("idle_rx_strobe", wr_strobe, 0);
        chk("idle_rx_rw", rw_data, 0);

        send_cmd(8'h7F);
        chk("id_read", tx_data, 32'hC001CAFE);
        chk("id_strobe", wr_strobe, 0);

        send_cmd(8'h83);
        send_rx(32'h12345678);
        chk("w3_strobe", wr_strobe, 7'b0001000);
        chk("w3_rw", rw_data, {96'h0, 32'h12345678, 32'h0});
`ifdef PICOVIEW_REGFILE_BURST_EN
        chk("w3_tx_adv", tx_data, 0);
`else
        chk("w3_tx_same", tx_data, 32'h12345678);
`endif
        step();
        chk("w3_strobe_off", wr_strobe, 0);

        send_cmd(8'h03);
        chk("r3", tx_data, 32'h12345678);
        send_cmd(8'h01);
        chk("r1_ro", tx_data, 32'hBBBB0001);
        send_cmd(8'h10);
        chk("r_unmapped", tx_data, 0);

        send_cmd(8'h80);
        send_rx(32'h1);
        chk("ctrl_pulse", ctrl_pulse, 32'h1);
        chk("ctrl_strobe", wr_strobe, 7'b0000001);
        chk("ctrl_rw", rw_data, {96'h0, 32'h12345678, 32'h0});
        step();
        chk("ctrl_off", ctrl_pulse, 0);
        chk("ctrl_strobe_off", wr_strobe, 0);

        send_cmd(8'h81);
        send_rx(32'hFFFF);
        chk("ro_w_strobe", wr_strobe, 7'b0000010);
        chk("ro_w_ctrl", ctrl_pulse, 0);
        chk("ro_w_rw", rw_data, {96'h0, 32'h12345678, 32'h0});

        send_cmd(8'h85);
        send_rx(32'h11111111);
        send_rx(32'h22222222);
        send_rx(32'h33333333);
`ifdef PICOVIEW_REGFILE_BURST_EN
        chk("burst_rw", rw_data,
            {32'h22222222, 32'h11111111, 32'h0, 32'h12345678, 32'h0});
        chk("burst_ctrl", ctrl_pulse, 32'h33333333);
        chk("burst_strobe", wr_strobe, 7'b0000001);
`else
        chk("fixed_rw", rw_data,
            {32'h0, 32'h33333333, 32'h0, 32'h12345678, 32'h0});
        chk("fixed_ctrl", ctrl_pulse, 0);
        chk("fixed_strobe", wr_strobe, 7'b0100000);
`endif

        send_cmd(8'h84);
        cmd = 8'h02;
        cmd_valid = 1'b1;
        rx_data = 32'h44444444;
        rx_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        rx_valid = 1'b0;
        chk("sim_strobe", wr_strobe, 7'b0010000);
        chk("sim_rw4", rw_data[95:64], 32'h44444444);
        chk("sim_tx", tx_data, 0);
        send_rx(32'h55555555);
        chk("sim_read_strobe", wr_strobe, 0);
        chk("sim_read_rw4", rw_data[95:64], 32'h44444444);
`ifdef PICOVIEW_REGFILE_BURST_EN
        chk("sim_read_tx", tx_data, 32'h12345678);
`else
        chk("sim_read_tx", tx_data, 0);
`endif

        send_cmd(8'hFF);
        send_rx(32'h9);
        chk("id_w_strobe", wr_strobe, 0);
        chk("id_w_tx", tx_data, 32'hC001CAFE);

        send_cmd(8'h90);
        send_rx(32'h1);
        chk("unm_w_strobe", wr_strobe, 0);
        chk("unm_w_ctrl", ctrl_pulse, 0);

        send_cmd(8'h82);
        send_rx(32'h66666666);
        chk("pre_rst_rw2", rw_data[31:0], 32'h66666666);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rw", rw_data, 0);
        chk("mid_rst_tx", tx_data, 0);
        chk("mid_rst_strobe", wr_strobe, 0);
        step();
        rst_n = 1'b1;
        step();
        send_rx(32'h77);
        chk("post_rst_strobe", wr_strobe, 0);
        chk("post_rst_rw", rw_data, 0);
        chk("post_rst_ctrl", ctrl_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
